thread_pc_fetch: RTL and testbench

- Fetch-stage PC generator for the 4-thread barrel pipeline.
- Holds one PC per hardware thread and picks the next eligible thread round-robin each cycle.
- Issues that thread's PC with its thread ID and a valid flag into the IF/ID stage register, which latches them as PC_in / thread_id_in / wb_ff_in.
- Applies branch redirects, per-thread halts and pipeline stalls (hazard).

---
 rtl/thread_pc_fetch.sv | 92 +++++++++
 tb/tb_thread_pc_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/thread_pc_fetch.sv
// Fetch PC generator for the 4-thread barrel pipeline.
// Ports: CLK/RST (sync, active-high), hazard stall, thread_en mask,
//   halt_req/halt_tid, br_taken/br_tid/br_target redirect in;
//   PC_out/thread_id_out/fetch_valid to IF/ID, thread_active out.
module thread_pc_fetch #(
  parameter int INSTMEM_LOG2_DEEP = 8,
  parameter logic [INSTMEM_LOG2_DEEP-1:0] START_PC0 = 8'h00,
  parameter logic [INSTMEM_LOG2_DEEP-1:0] START_PC1 = 8'h40,
  parameter logic [INSTMEM_LOG2_DEEP-1:0] START_PC2 = 8'h80,
  parameter logic [INSTMEM_LOG2_DEEP-1:0] START_PC3 = 8'hC0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         hazard,
  input  logic [3:0]                   thread_en,
  input  logic                         halt_req,
  input  logic [1:0]                   halt_tid,
  input  logic                         br_taken,
  input  logic [1:0]                   br_tid,
  input  logic [INSTMEM_LOG2_DEEP-1:0] br_target,
  output logic [INSTMEM_LOG2_DEEP-1:0] PC_out,
  output logic [1:0]                   thread_id_out,
  output logic                         fetch_valid,
  output logic [3:0]                   thread_active
);

  localparam int AW = INSTMEM_LOG2_DEEP;

  logic [AW-1:0] pc [4];
  logic [3:0]    halted;
  logic [1:0]    last_tid;
  logic [3:0]    elig;
  logic [1:0]    sel;
  logic          none_elig;
  logic [AW-1:0] iss_pc;

  assign elig          = thread_en & ~halted;
  assign thread_active = elig;

  // Scan farthest-first so the nearest eligible thread after
  // last_tid wins; offset 4 wraps back onto last_tid itself.
  always_comb begin
    logic [1:0] cand;
    sel       = last_tid;
    none_elig = 1'b1;
    cand      = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_tid + 2'(k);
      if (elig[cand]) begin
        sel       = cand;
        none_elig = 1'b0;
      end
    end
  end

  // Redirect bypass keeps the wrong-path PC out of the pipe.
  assign iss_pc = (br_taken && br_tid == sel) ? br_target
                                              : pc[sel];

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc[0]         <= START_PC0;
      pc[1]         <= START_PC1;
      pc[2]         <= START_PC2;
      pc[3]         <= START_PC3;
      halted        <= 4'b0000;
      last_tid      <= 2'd3;
      PC_out        <= '0;
      thread_id_out <= '0;
      fetch_valid   <= 1'b0;
    end else begin
      if (br_taken)
        pc[br_tid] <= br_target;
      // Issue write comes last so it overrides a same-thread redirect
      // with target+1.
      if (!hazard) begin
        if (!none_elig) begin
          PC_out        <= iss_pc;
          thread_id_out <= sel;
          fetch_valid   <= 1'b1;
          last_tid      <= sel;
          pc[sel]       <= AW'(iss_pc + 1'b1);
        end else begin
          fetch_valid   <= 1'b0;
        end
      end
      if (halt_req)
        halted[halt_tid] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_thread_pc_fetch.sv
// Directed self-checking bench for thread_pc_fetch.
// Second instance uses START_PC3=FE for the PC wrap case.
module tb_thread_pc_fetch;

  logic       CLK = 1'b0;
  logic       RST;
  logic       hazard;
  logic [3:0] thread_en;
  logic       halt_req;
  logic [1:0] halt_tid;
  logic       br_taken;
  logic [1:0] br_tid;
  logic [7:0] br_target;

  logic [7:0] PC_out, w_pc;
  logic [1:0] thread_id_out, w_tid;
  logic       fetch_valid, w_valid;
  logic [3:0] thread_active, w_active;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  thread_pc_fetch u_dut (
    .CLK(CLK), .RST(RST), .hazard(hazard),
    .thread_en(thread_en), .halt_req(halt_req),
    .halt_tid(halt_tid), .br_taken(br_taken),
    .br_tid(br_tid), .br_target(br_target),
    .PC_out(PC_out), .thread_id_out(thread_id_out),
    .fetch_valid(fetch_valid),
    .thread_active(thread_active)
  );

  thread_pc_fetch #(.START_PC3(8'hFE)) u_wrap (
    .CLK(CLK), .RST(RST), .hazard(hazard),
    .thread_en(thread_en), .halt_req(halt_req),
    .halt_tid(halt_tid), .br_taken(br_taken),
    .br_tid(br_tid), .br_target(br_target),
    .PC_out(w_pc), .thread_id_out(w_tid),
    .fetch_valid(w_valid),
    .thread_active(w_active)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic iss(input string tag,
                     input logic [1:0] tid,
                     input logic [7:0] pc);
    chk({tag, "_tid"}, 32'(thread_id_out), 32'(tid));
    chk({tag, "_pc"}, 32'(PC_out), 32'(pc));
    chk({tag, "_vld"}, 32'(fetch_valid), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; hazard = 1'b0; thread_en = 4'hF;
    halt_req = 1'b0; halt_tid = 2'd0;
    br_taken = 1'b0; br_tid = 2'd0; br_target = 8'h00;

    // 1: reset state and round-robin
    tick();
    chk("rst_pc", 32'(PC_out), 32'h0);
    chk("rst_tid", 32'(thread_id_out), 32'h0);
    chk("rst_vld", 32'(fetch_valid), 32'h0);
    chk("rst_act", 32'(thread_active), 32'hF);
    RST = 1'b0;
    tick(); iss("rr0", 2'd0, 8'h00);
    tick(); iss("rr1", 2'd1, 8'h40);
    tick(); iss("rr2", 2'd2, 8'h80);
    tick(); iss("rr3", 2'd3, 8'hC0);
    tick(); iss("rr4", 2'd0, 8'h01);
    tick(); iss("rr5", 2'd1, 8'h41);
    tick(); iss("rr6", 2'd2, 8'h81);
    tick(); iss("rr7", 2'd3, 8'hC1);

    // 2: stall
    do_reset();
    tick(); iss("st0", 2'd0, 8'h00);
    tick(); iss("st1", 2'd1, 8'h40);
    hazard = 1'b1;
    tick(); iss("stall_a", 2'd1, 8'h40);
    tick(); iss("stall_b", 2'd1, 8'h40);
    tick(); iss("stall_c", 2'd1, 8'h40);
    hazard = 1'b0;
    tick(); iss("st2", 2'd2, 8'h80);
    tick(); iss("st3", 2'd3, 8'hC0);
    tick(); iss("st4", 2'd0, 8'h01);
    tick(); iss("st5", 2'd1, 8'h41);

    // 3: redirect bypass, then redirect under stall
    br_taken = 1'b1; br_tid = 2'd2; br_target = 8'h10;
    tick(); iss("byp", 2'd2, 8'h10);
    br_taken = 1'b0;
    tick(); iss("byp_t3", 2'd3, 8'hC1);
    tick(); iss("byp_t0", 2'd0, 8'h02);
    tick(); iss("byp_t1", 2'd1, 8'h42);
    tick(); iss("byp_nxt", 2'd2, 8'h11);
    hazard = 1'b1; br_taken = 1'b1;
    tick(); iss("hz_br_hold", 2'd2, 8'h11);
    hazard = 1'b0; br_taken = 1'b0;
    tick(); iss("hz_t3", 2'd3, 8'hC2);
    tick(); iss("hz_t0", 2'd0, 8'h03);
    tick(); iss("hz_t1", 2'd1, 8'h43);
    tick(); iss("hz_br_nxt", 2'd2, 8'h10);

    // 4: halt and skip, then halt everything
    do_reset();
    tick(); iss("h0", 2'd0, 8'h00);
    halt_req = 1'b1; halt_tid = 2'd1;
    tick(); iss("h_req", 2'd1, 8'h40);
    halt_req = 1'b0;
    chk("h_act", 32'(thread_active), 32'hD);
    tick(); iss("h2", 2'd2, 8'h80);
    tick(); iss("h3", 2'd3, 8'hC0);
    tick(); iss("h4", 2'd0, 8'h01);
    tick(); iss("h5", 2'd2, 8'h81);
    halt_req = 1'b1; halt_tid = 2'd0;
    tick(); iss("ha0", 2'd3, 8'hC1);
    halt_tid = 2'd2;
    tick(); iss("ha2", 2'd2, 8'h82);
    halt_tid = 2'd3;
    tick(); iss("ha3", 2'd3, 8'hC2);
    halt_req = 1'b0;
    br_taken = 1'b1; br_tid = 2'd1; br_target = 8'h55;
    tick();
    br_taken = 1'b0;
    chk("none_vld", 32'(fetch_valid), 32'h0);
    chk("none_pc", 32'(PC_out), 32'hC2);
    chk("none_tid", 32'(thread_id_out), 32'h3);
    chk("none_act", 32'(thread_active), 32'h0);

    // 6: reset during stall with halt and redirect pending
    RST = 1'b1; hazard = 1'b1;
    halt_req = 1'b1; halt_tid = 2'd0;
    br_taken = 1'b1; br_tid = 2'd1; br_target = 8'h77;
    tick();
    chk("mr_pc", 32'(PC_out), 32'h0);
    chk("mr_tid", 32'(thread_id_out), 32'h0);
    chk("mr_vld", 32'(fetch_valid), 32'h0);
    chk("mr_act", 32'(thread_active), 32'hF);
    RST = 1'b0; hazard = 1'b0;
    halt_req = 1'b0; br_taken = 1'b0;
    tick(); iss("mr0", 2'd0, 8'h00);
    tick(); iss("mr1", 2'd1, 8'h40);
    tick(); iss("mr2", 2'd2, 8'h80);
    tick(); iss("mr3", 2'd3, 8'hC0);
    tick(); iss("mr4", 2'd0, 8'h01);

    // 5: single-thread enable and PC wrap
    RST = 1'b1; thread_en = 4'b1000;
    tick();
    RST = 1'b0;
    tick();
    chk("w0_pc", 32'(w_pc), 32'hFE);
    chk("w0_tid", 32'(w_tid), 32'h3);
    chk("w0_vld", 32'(w_valid), 32'h1);
    chk("w0_act", 32'(w_active), 32'h8);
    tick();
    chk("w1_pc", 32'(w_pc), 32'hFF);
    chk("w1_tid", 32'(w_tid), 32'h3);
    tick();
    chk("w2_pc", 32'(w_pc), 32'h00);
    chk("w2_tid", 32'(w_tid), 32'h3);
    tick();
    chk("w3_pc", 32'(w_pc), 32'h01);
    chk("w3_tid", 32'(w_tid), 32'h3);
    iss("sp_main", 2'd3, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
